// File: rtl/seq_scan_pkg.sv
// Shared types and defaults for the word-level "101" scan controller.
package seq_scan_pkg;

  localparam int unsigned SCAN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } det_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/seq101_det.sv
// Bit-serial overlapping "101" detector with enable and synchronous clear.
module seq101_det
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic d,
  output logic out
);

  det_state_t state;

  // State only moves when enabled, so context survives idle gaps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
      out   <= 1'b0;
    end else if (clr) begin
      state <= S0;
      out   <= 1'b0;
    end else if (en) begin
      out <= (state == S2) && d;
      case (state)
        S0:      state <= d ? S1 : S0;
        S1:      state <= d ? S1 : S2;
        S2:      state <= d ? S1 : S0;
        default: state <= S0;
      endcase
    end else begin
      out <= 1'b0;
    end
  end

  a_s0_d1: assert property (@(posedge clk) disable iff (rst)
    (en && !clr && state == S0 && d) |=> (state == S1 && !out));
  a_s0_d0: assert property (@(posedge clk) disable iff (rst)
    (en && !clr && state == S0 && !d) |=> (state == S0 && !out));
  a_s1_d1: assert property (@(posedge clk) disable iff (rst)
    (en && !clr && state == S1 && d) |=> (state == S1 && !out));
  a_s1_d0: assert property (@(posedge clk) disable iff (rst)
    (en && !clr && state == S1 && !d) |=> (state == S2 && !out));
  a_s2_d1: assert property (@(posedge clk) disable iff (rst)
    (en && !clr && state == S2 && d) |=> (state == S1 && out));
  a_s2_d0: assert property (@(posedge clk) disable iff (rst)
    (en && !clr && state == S2 && !d) |=> (state == S0 && !out));
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (!en && !clr) |=> (!out && $stable(state)));

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-level controller: shifts a word MSB-first through the "101" detector
// and returns the per-bit match mask and match count.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned W     = SCAN_W_DEFAULT,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             keep_ctx,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_mask,
  output logic [CNT_W-1:0] res_count
);

  localparam int unsigned BIT_W = $clog2(W);

  scan_state_t      state;
  logic [W-1:0]     sreg;
  logic [BIT_W-1:0] bit_cnt;
  logic             det_out;
  logic             accept;
  logic             det_en;
  logic             det_clr;

  assign in_ready = (state == IDLE) || ((state == DONE) && res_ready);
  assign accept   = in_valid && in_ready;
  assign det_en   = (state == SHIFT);
  assign det_clr  = accept && !keep_ctx;

  seq101_det u_det (
    .clk (clk),
    .rst (rst),
    .en  (det_en),
    .clr (det_clr),
    .d   (sreg[W-1]),
    .out (det_out)
  );

  // The match pulse lags its bit by one cycle, so the mask shifts in from
  // SHIFT cycle 1 through DRAIN: W pulses land MSB-first in bit order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      res_valid <= 1'b0;
      res_mask  <= '0;
      res_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg      <= in_data;
            bit_cnt   <= '0;
            res_mask  <= '0;
            res_count <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          sreg    <= {sreg[W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (bit_cnt != '0) begin
            res_mask  <= {res_mask[W-2:0], det_out};
            res_count <= res_count + CNT_W'(det_out);
          end
          if (bit_cnt == BIT_W'(W - 1)) state <= DRAIN;
        end
        DRAIN: begin
          res_mask  <= {res_mask[W-2:0], det_out};
          res_count <= res_count + CNT_W'(det_out);
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (accept) begin
              sreg      <= in_data;
              bit_cnt   <= '0;
              res_mask  <= '0;
              res_count <= '0;
              state     <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_latency: assert property (@(posedge clk) disable iff (rst)
    accept |=> ##(W + 1) $rose(res_valid));
  a_res_stable: assert property (@(posedge clk) disable iff (rst)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_mask) && $stable(res_count)));
  a_busy_no_ready: assert property (@(posedge clk) disable iff (rst)
    (state == SHIFT || state == DRAIN) |-> !in_ready);

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Randomized and directed bench for seq_scan_ctrl against a bit-history model.
module tb_seq_scan_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          keep_ctx = 1'b0;
  logic          in_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          res_valid;
  logic [W-1:0]  res_mask;
  logic [CW-1:0] res_count;

  seq_scan_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .keep_ctx  (keep_ctx),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_mask  (res_mask),
    .res_count (res_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] mask;
    int           cnt;
    int           ready_at;
  } exp_t;

  exp_t q[$];
  bit   hist[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // A match completes on a 1 whose two predecessors in the stream were 1,0
  task automatic model_accept(input logic [W-1:0] data, input logic keep);
    exp_t e;
    e.mask = '0;
    if (!keep) hist.delete();
    for (int i = W - 1; i >= 0; i--) begin
      if (hist.size() == 2 && hist[0] == 1'b1 && hist[1] == 1'b0 && data[i]) e.mask[i] = 1'b1;
      hist.push_back(data[i]);
      if (hist.size() > 2) void'(hist.pop_front());
    end
    e.cnt      = $countones(e.mask);
    e.ready_at = cyc + W + 2;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    logic rv_exp;
    logic ir_exp;
    if (rst) begin
      q.delete();
      hist.delete();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_mask", 32'(res_mask), 32'd0);
      chk("rst_res_count", 32'(res_count), 32'd0);
    end else begin
      rv_exp = (q.size() > 0) && (cyc >= q[0].ready_at);
      chk("res_valid", 32'(res_valid), 32'(rv_exp));
      if (rv_exp) begin
        chk("res_mask", 32'(res_mask), 32'(q[0].mask));
        chk("res_count", 32'(res_count), 32'(q[0].cnt));
      end
      ir_exp = (q.size() == 0) || (rv_exp && res_ready);
      chk("in_ready", 32'(in_ready), 32'(ir_exp));
      if (rv_exp && res_ready) void'(q.pop_front());
      if (in_valid && ir_exp) model_accept(in_data, keep_ctx);
    end
  end

  task automatic send(input logic [W-1:0] data, input logic keep);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = data;
    keep_ctx = keep;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    keep_ctx = 1'($urandom);
  endtask

  task automatic get_result(input logic [W-1:0] em, input int ec, input bit lit, input int hold);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1'b1; break; end
    end
    chk("result_timeout", 32'(ok), 32'd1);
    if (lit) begin
      chk("lit_mask", 32'(res_mask), 32'(em));
      chk("lit_count", 32'(res_count), 32'(ec));
    end
    repeat (hold) @(negedge clk);
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
  endtask

  task automatic count_latency(input string name);
    int n = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (res_valid) begin seen = 1'b1; break; end
    end
    chk(name, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(W + 1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [W-1:0] m0;
    logic [CW-1:0] c0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // basic pattern and latency
    send(8'b1010_1010, 1'b0);
    count_latency("latency_basic");
    get_result(8'b0010_1010, 3, 1'b1, 0);

    // overlap and flat words
    send(8'b1011_0101, 1'b0); get_result(8'b0010_0101, 3, 1'b1, 0);
    send(8'h00, 1'b0);        get_result(8'h00, 0, 1'b1, 0);
    send(8'hFF, 1'b0);        get_result(8'h00, 0, 1'b1, 0);

    // context carry across words
    send(8'b0000_0010, 1'b0); get_result(8'h00, 0, 1'b1, 3);
    send(8'b1000_0000, 1'b1); get_result(8'b1000_0000, 1, 1'b1, 0);
    send(8'b0000_0010, 1'b0); get_result(8'h00, 0, 1'b1, 0);
    repeat (4) @(posedge clk);
    send(8'b1000_0000, 1'b0); get_result(8'h00, 0, 1'b1, 0);

    // backpressure then accept on the releasing edge
    send(8'b1011_0101, 1'b0);
    begin : wait_done
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (res_valid) break;
      end
    end
    m0 = res_mask;
    c0 = res_count;
    chk("bp_first_mask", 32'(m0), 32'h25);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_mask_stable", 32'(res_mask), 32'(m0));
      chk("bp_count_stable", 32'(res_count), 32'(c0));
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1; in_valid = 1'b1; in_data = 8'b1010_1010; keep_ctx = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_high", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    res_ready = 1'b0; in_valid = 1'b0; in_data = 8'h5A;
    count_latency("latency_b2b");
    get_result(8'b0010_1010, 3, 1'b1, 0);

    // reset during SHIFT cycle 3 drops the word and clears the detector
    send(8'b1010_1010, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(res_valid), 32'd0);
    end
    send(8'b1010_0000, 1'b1); get_result(8'b0010_0000, 1, 1'b1, 0);

    // randomized words, context modes and result stalls
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      if ($urandom_range(0, 4) == 0) d = ($urandom_range(0, 1) == 1) ? 8'h55 : 8'hAA;
      send(d, 1'($urandom_range(0, 1)));
      get_result('0, 0, 1'b0, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // held res_ready gives back-to-back words
    @(posedge clk); #1 res_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      in_valid = 1'b1; in_data = W'($urandom); keep_ctx = 1'($urandom);
      begin : wait_acc
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (in_ready) break;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (W + 4) @(posedge clk);
    #1 res_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Word-level controller for the serial "101" detector. It accepts a parallel data word over a valid/ready handshake and shifts it MSB-first, one bit per cycle, into an owned instance of the detector. It collects the per-bit match pulses into a position mask and a match count, then returns them over a second valid/ready handshake. It sits between the parallel data path and the bit-serial detector, so a word producer never drives `d` directly.

## Interface
- `W`, default 8: data word width; legal range ≥ 2.
- `CNT_W`, default `$clog2(W+1)`: width of the match count.
- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `keep_ctx` in 1: 1 = detector state carries across words; 0 = detector cleared at each word accept. Sampled on the accept edge.
- `in_valid` in 1: producer offers `in_data`.
- `in_ready` out 1: controller can accept a word.
- `in_data` in W: word to scan; bit W-1 is shifted first.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes the result.
- `res_mask` out W: bit i = 1 when a "101" completes on data bit i.
- `res_count` out CNT_W: popcount of `res_mask`.

## Operation
- The controller FSM is in `seq_scan_pkg::scan_state_t` and has four states: IDLE, SHIFT, DRAIN, DONE.
- **IDLE:** `in_ready`=1. On `in_valid`, capture `in_data` into the shift register, clear the bit counter, mask and count, and go to SHIFT. If `keep_ctx`=0, pulse a synchronous clear into the detector (state S0, `out`=0).
- **SHIFT:** lasts exactly W cycles.
  - In cycle k (k = 0..W-1), `d` = shift register MSB (data bit W-1-k) and detector enable = 1.
  - The shift register moves left each cycle.
- **DRAIN:** one cycle with detector enable = 0. It captures the registered match pulse for the last bit.
- **DONE:** `res_valid`=1 and `res_mask`/`res_count` are held stable.
  - Leave DONE on `res_ready`.
  - `in_ready` = (IDLE) or (DONE and `res_ready`). A simultaneous accept goes straight to SHIFT; otherwise go to IDLE.
- **Detector behaviour:**
  - Encoding: S0 = waiting, S1 = saw 1, S2 = saw 10.
  - When enabled, it follows: S0 -d→ S1 / stays S0; S1 -d→ S1 / else S2; S2 -d→ S1 / else S0.
  - `out` is registered: `out` ← (state==S2 and d) when enabled, else `out` ← 0.
  - Matches overlap: "10101" yields 2.
- **Mask and count:** when the detector `out`=1 during SHIFT cycle k (k ≥ 1) or during DRAIN, set the mask bit for the bit presented one cycle earlier and increment the count.
  - Count saturation is unreachable because CNT_W covers W.
- **Cross-word matches:** with `keep_ctx`=1, a match straddling two words is credited to the later word, at the bit index where it completes.

## Timing
- **Reset:** on `rst`, asynchronously:
  - state = IDLE, detector = S0, detector `out` = 0;
  - `in_ready` = 1, `res_valid` = 0, `res_mask` = 0, `res_count` = 0.
  - Reset in any state drops the in-flight word and any pending result, with no partial result emitted.
- **Latency:** `res_valid` rises W+1 edges after the accept edge.
- **Throughput:** one word per W+2 cycles when `res_ready` is held at 1.
- **Handshake rules:**
  - `in_data` is sampled only on the accept edge.
  - `res_*` outputs are stable while `res_valid`=1 and `res_ready`=0.
  - `in_ready` is 0 in SHIFT and DRAIN, regardless of `in_valid`.
- **Detector context:** it does not advance in IDLE, DRAIN or DONE. State is held there, so `keep_ctx` context survives arbitrary idle gaps.

## Structure
- Package `seq_scan_pkg` holds:
  - `det_state_t` (S0=2'b00, S1=2'b01, S2=2'b10);
  - `scan_state_t`;
  - the default W.
- Sub-module `seq101_det` contains the detector:
  - ports `clk`, `rst`, `en`, `clr`, `d`, `out`;
  - it carries its own per-state SVA, gated by `en`.
- `seq_scan_ctrl` holds the FSM, shift register, bit counter, mask and count registers, plus SVA for latency and handshake stability.

## Test plan
- **Basic pattern:** W=8, `keep_ctx`=0, `in_data`=8'b1010_1010 → `res_mask`=8'b0010_1010, `res_count`=3; `res_valid` rises exactly 9 edges after accept.
- **Overlap:** `in_data`=8'b1011_0101 → `res_mask`=8'b0010_0101, `res_count`=3. `in_data`=8'h00 or 8'hFF → mask 0, count 0.
- **Context carry:** word 8'b0000_0010 then word 8'b1000_0000.
  - `keep_ctx`=1 → second result mask 8'b1000_0000, count 1.
  - `keep_ctx`=0 → second result mask 0, count 0.
  - The first result is 0 in both cases.
- **Backpressure:** hold `res_ready`=0 for 5 cycles in DONE → outputs stable and `in_ready`=0. Then raise `res_ready`=1 with `in_valid`=1 → the next word is accepted on the same edge, and its result arrives W+1 edges later.
- **Reset mid-scan:** assert `rst` in SHIFT cycle 3 → next cycle `res_valid`=0, `in_ready`=1, and no result appears. The next word 8'b1010_0000 gives mask 8'b0010_0000 and count 1, confirming the detector restarted from S0.
